// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: PC source select, fetch FSM states and PC step.
// Used by the branch resolver, the fetch stage and the next-PC calculator.
package cpu_pkg;

  typedef enum logic [1:0] {
    PCSRC_JR  = 2'b00,
    PCSRC_J   = 2'b01,
    PCSRC_BR  = 2'b10,
    PCSRC_SEQ = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Branch offsets are encoded in words; this turns one into a signed byte offset.
  function automatic logic [31:0] branch_byte_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect-target calculator for JR, J/JAL and taken branches.
// Reports whether the raw target is not word aligned.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [1:0]  pcsrc,
  input  logic [31:0] ex_pc_plus4,
  input  logic [31:0] ex_rs_data,
  input  logic [25:0] ex_jindex,
  input  logic [15:0] ex_imm16,
  output logic [31:0] target,
  output logic        misalign
);

  always_comb begin
    target = ex_pc_plus4;
    case (pcsrc)
      PCSRC_JR:  target = ex_rs_data;
      PCSRC_J:   target = {ex_pc_plus4[31:28], ex_jindex, 2'b00};
      PCSRC_BR:  target = ex_pc_plus4 + branch_byte_offset(ex_imm16);
      default:   target = ex_pc_plus4;
    endcase
  end

  assign misalign = |target[1:0];

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage with one outstanding request.
// Optional misaligned-target trap is enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [1:0]  PCSrcs,
  input  logic [31:0] ex_pc_plus4,
  input  logic [31:0] ex_rs_data,
  input  logic [25:0] ex_jindex,
  input  logic [15:0] ex_imm16,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic         if_valid_next;
  logic [31:0]  if_instr_next, if_pc_next;
  logic         misalign_err_next;

  logic         redirect;
  logic [31:0]  raw_target;
  logic         raw_misalign;
  logic [31:0]  redirect_pc;

  next_pc_calc u_next_pc_calc (
    .pcsrc       (PCSrcs),
    .ex_pc_plus4 (ex_pc_plus4),
    .ex_rs_data  (ex_rs_data),
    .ex_jindex   (ex_jindex),
    .ex_imm16    (ex_imm16),
    .target      (raw_target),
    .misalign    (raw_misalign)
  );

  assign redirect = ex_valid && (PCSrcs != PCSRC_SEQ);

`ifdef PC_ALIGN_CHECK_EN
  assign redirect_pc       = raw_misalign ? EXC_VECTOR : raw_target;
  assign misalign_err_next = redirect && raw_misalign;
`else
  // Misaligned targets are silently rounded down to a word boundary.
  assign redirect_pc       = raw_misalign ? {raw_target[31:2], 2'b00} : raw_target;
  assign misalign_err_next = 1'b0;
`endif

  assign imem_addr = pc;

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    if_valid_next = 1'b0;
    if_instr_next = if_instr;
    if_pc_next    = if_pc;
    imem_req      = 1'b0;
    case (state)
      IDLE: begin
        imem_req = !reset && !stall && !redirect;
        if (redirect) begin
          pc_next = redirect_pc;
        end else if (imem_req && imem_gnt) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        // A redirect makes the outstanding response stale; wait it out in DROP if it has not arrived.
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          if_valid_next = 1'b1;
          if_instr_next = imem_rdata;
          if_pc_next    = pc;
          pc_next       = pc + PC_STEP;
          state_next    = IDLE;
        end
      end
      DROP: begin
        if (redirect) pc_next = redirect_pc;
        if (imem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_VECTOR;
      if_valid     <= 1'b0;
      if_instr     <= 32'h0;
      if_pc        <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      if_valid     <= if_valid_next;
      if_instr     <= if_instr_next;
      if_pc        <= if_pc_next;
      misalign_err <= misalign_err_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch stage.
module tb_pc_fetch;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset, stall, ex_valid;
  logic [1:0]  PCSrcs;
  logic [31:0] ex_pc_plus4, ex_rs_data;
  logic [25:0] ex_jindex;
  logic [15:0] ex_imm16;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, misalign_err;
  logic [31:0] if_instr, if_pc;

  int total = 0;
  int bad = 0;

  // Model: architectural PC, whether a request is outstanding, and whether it went stale.
  logic [31:0] m_pc;
  bit          m_out, m_stale;
  logic        exp_req, exp_valid, exp_mis;
  logic [31:0] exp_addr, exp_instr, exp_pc;
  logic        obs_req, obs_valid, obs_mis;
  logic [31:0] obs_addr, obs_instr, obs_pc;

  always #5 clk = ~clk;

  pc_fetch #(
    .RESET_VECTOR (RESET_VECTOR),
    .EXC_VECTOR   (EXC_VECTOR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .PCSrcs       (PCSrcs),
    .ex_pc_plus4  (ex_pc_plus4),
    .ex_rs_data   (ex_rs_data),
    .ex_jindex    (ex_jindex),
    .ex_imm16     (ex_imm16),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .misalign_err (misalign_err)
  );

  // Drives one cycle, samples request outputs before the edge and delivery outputs after it.
  task automatic tick(input bit rst, input bit st, input bit gn, input bit rv,
                      input logic [31:0] rd, input bit exv, input logic [1:0] src,
                      input logic [31:0] p4, input logic [31:0] rs,
                      input logic [25:0] ji, input logic [15:0] im);
    bit          redir, mis;
    logic [31:0] tgt, off;
    reset = rst; stall = st; imem_gnt = gn; imem_rvalid = rv; imem_rdata = rd;
    ex_valid = exv; PCSrcs = src; ex_pc_plus4 = p4; ex_rs_data = rs;
    ex_jindex = ji; ex_imm16 = im;
    #1;
    obs_req = imem_req;
    obs_addr = imem_addr;
    redir = exv && (src != 2'b11);
    case (src)
      2'b00:   tgt = rs;
      2'b01:   tgt = {p4[31:28], ji, 2'b00};
      2'b10:   begin off = {{16{im[15]}}, im}; tgt = p4 + off * 4; end
      default: tgt = m_pc;
    endcase
    mis = redir && (tgt % 4 != 0);
`ifdef PC_ALIGN_CHECK_EN
    if (mis) tgt = EXC_VECTOR;
    exp_mis = mis;
`else
    tgt[1:0] = 2'b00;
    exp_mis = 1'b0;
`endif
    exp_addr = m_pc;
    if (rst) begin
      exp_req = 1'b0; m_pc = RESET_VECTOR; m_out = 1'b0; m_stale = 1'b0;
      exp_valid = 1'b0; exp_instr = 32'h0; exp_pc = 32'h0; exp_mis = 1'b0;
    end else begin
      exp_req = !m_out && !st && !redir;
      exp_valid = 1'b0;
      if (!m_out) begin
        if (redir) m_pc = tgt;
        else if (exp_req && gn) begin m_out = 1'b1; m_stale = 1'b0; end
      end else begin
        if (rv) begin
          if (!m_stale && !redir) begin
            exp_valid = 1'b1; exp_instr = rd; exp_pc = m_pc; m_pc = m_pc + 4;
          end
          m_out = 1'b0;
        end else if (redir) begin
          m_stale = 1'b1;
        end
        if (redir) m_pc = tgt;
      end
    end
    @(posedge clk);
    #1;
    obs_valid = if_valid;
    obs_instr = if_instr;
    obs_pc = if_pc;
    obs_mis = misalign_err;
  endtask

  task automatic tick_plain(input bit st, input bit gn, input bit rv, input logic [31:0] rd);
    tick(1'b0, st, gn, rv, rd, 1'b0, 2'b11, 32'h0, 32'h0, 26'h0, 16'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 2'b11, 32'h0, 32'h0, 26'h0, 16'h0);
    total++; if (obs_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%0b exp=0", obs_req); end
    total++; if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", obs_valid); end
    total++; if (obs_pc !== 32'h0 || obs_instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_ifregs got pc=%h instr=%h exp 0", obs_pc, obs_instr); end
    total++; if (obs_mis !== 1'b0) begin bad++; $display("[TB] FAIL reset_mis got=%0b exp=0", obs_mis); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      tick_plain(1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (obs_req !== 1'b1 || obs_addr !== 32'(i * 4)) begin bad++; $display("[TB] FAIL seq_issue got req=%0b addr=%h exp req=1 addr=%h", obs_req, obs_addr, 32'(i * 4)); end
      total++; if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL seq_nopulse got=%0b exp=0", obs_valid); end
      tick_plain(1'b0, 1'b0, 1'b1, 32'h2408_0001);
      total++; if (obs_req !== 1'b0) begin bad++; $display("[TB] FAIL seq_busyreq got=%0b exp=0", obs_req); end
      total++; if (obs_valid !== 1'b1 || obs_pc !== 32'(i * 4) || obs_instr !== 32'h2408_0001) begin bad++; $display("[TB] FAIL seq_deliver got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=24080001", obs_valid, obs_pc, obs_instr, 32'(i * 4)); end
    end
  endtask

  task automatic test_redirect_idle();
    tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0000_0100, 26'h0, 16'h0);
    total++; if (obs_req !== 1'b0) begin bad++; $display("[TB] FAIL jr_req got=%0b exp=0", obs_req); end
    tick_plain(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin bad++; $display("[TB] FAIL jr_addr got req=%0b addr=%h exp req=1 addr=00000100", obs_req, obs_addr); end
  endtask

  task automatic test_branch_busy();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'b10, 32'h0000_0040, 32'h0, 26'h0, 16'hFFFE);
    total++; if (obs_req !== 1'b0) begin bad++; $display("[TB] FAIL br_req got=%0b exp=0", obs_req); end
    tick_plain(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    total++; if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL br_stale got=%0b exp=0", obs_valid); end
    tick_plain(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'h38) begin bad++; $display("[TB] FAIL br_addr got req=%0b addr=%h exp req=1 addr=00000038", obs_req, obs_addr); end
  endtask

  task automatic test_jump_same_cycle();
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b1, 2'b01, 32'hA000_0010, 32'h0, 26'h000_0040, 16'h0);
    total++; if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL j_drop got=%0b exp=0", obs_valid); end
    tick_plain(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'hA000_0100) begin bad++; $display("[TB] FAIL j_addr got req=%0b addr=%h exp req=1 addr=a0000100", obs_req, obs_addr); end
    tick_plain(1'b0, 1'b0, 1'b1, 32'h0C00_0123);
    total++; if (obs_valid !== 1'b1 || obs_pc !== 32'hA000_0100 || obs_instr !== 32'h0C00_0123) begin bad++; $display("[TB] FAIL j_deliver got v=%0b pc=%h instr=%h exp v=1 pc=a0000100 instr=0c000123", obs_valid, obs_pc, obs_instr); end
  endtask

  task automatic test_stall_and_reset_busy();
    for (int i = 0; i < 5; i++) begin
      tick_plain(1'b1, 1'b1, 1'b0, 32'h0);
      total++; if (obs_req !== 1'b0 || obs_addr !== 32'hA000_0104) begin bad++; $display("[TB] FAIL stall_hold got req=%0b addr=%h exp req=0 addr=a0000104", obs_req, obs_addr); end
    end
    tick_plain(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'hA000_0104) begin bad++; $display("[TB] FAIL stall_release got req=%0b addr=%h exp req=1 addr=a0000104", obs_req, obs_addr); end
    tick(1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_0000, 1'b0, 2'b11, 32'h0, 32'h0, 26'h0, 16'h0);
    total++; if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstbusy_valid got=%0b exp=0", obs_valid); end
    tick_plain(1'b0, 1'b1, 1'b1, 32'h5555_5555);
    total++; if (obs_req !== 1'b1 || obs_addr !== RESET_VECTOR || obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstbusy_after got req=%0b addr=%h v=%0b exp req=1 addr=00000000 v=0", obs_req, obs_addr, obs_valid); end
    tick_plain(1'b0, 1'b0, 1'b1, 32'h0000_0042);
    total++; if (obs_valid !== 1'b1 || obs_pc !== RESET_VECTOR) begin bad++; $display("[TB] FAIL rstbusy_deliver got v=%0b pc=%h exp v=1 pc=00000000", obs_valid, obs_pc); end
  endtask

  task automatic test_misalign();
    logic        want_mis;
    logic [31:0] want_addr;
`ifdef PC_ALIGN_CHECK_EN
    want_mis = 1'b1; want_addr = EXC_VECTOR;
`else
    want_mis = 1'b0; want_addr = 32'h0000_0100;
`endif
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0000_0102, 26'h0, 16'h0);
    total++; if (obs_mis !== want_mis) begin bad++; $display("[TB] FAIL mis_pulse got=%0b exp=%0b", obs_mis, want_mis); end
    tick_plain(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (obs_req !== 1'b1 || obs_addr !== want_addr) begin bad++; $display("[TB] FAIL mis_addr got req=%0b addr=%h exp req=1 addr=%h", obs_req, obs_addr, want_addr); end
    total++; if (obs_mis !== 1'b0) begin bad++; $display("[TB] FAIL mis_width got=%0b exp=0", obs_mis); end
    tick_plain(1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit          rst, st, gn, rv, exv;
      logic [31:0] rs, p4;
      rst = ($urandom % 60) == 0;
      st  = ($urandom % 4) == 0;
      gn  = $urandom % 2;
      rv  = m_out && (($urandom % 3) == 0);
      exv = ($urandom % 6) == 0;
      rs  = $urandom;
      if ($urandom % 2) rs[1:0] = 2'b00;
      p4  = $urandom;
      p4[1:0] = 2'b00;
      tick(rst, st, gn, rv, $urandom, exv, 2'($urandom), p4, rs, 26'($urandom), 16'($urandom));
      total++; if (obs_req !== exp_req) begin bad++; $display("[TB] FAIL rnd_req n=%0d got=%0b exp=%0b", n, obs_req, exp_req); end
      total++; if (obs_addr !== exp_addr) begin bad++; $display("[TB] FAIL rnd_addr n=%0d got=%h exp=%h", n, obs_addr, exp_addr); end
      total++; if (obs_valid !== exp_valid) begin bad++; $display("[TB] FAIL rnd_valid n=%0d got=%0b exp=%0b", n, obs_valid, exp_valid); end
      total++; if (obs_pc !== exp_pc || obs_instr !== exp_instr) begin bad++; $display("[TB] FAIL rnd_ifregs n=%0d got pc=%h instr=%h exp pc=%h instr=%h", n, obs_pc, obs_instr, exp_pc, exp_instr); end
      total++; if (obs_mis !== exp_mis) begin bad++; $display("[TB] FAIL rnd_mis n=%0d got=%0b exp=%0b", n, obs_mis, exp_mis); end
    end
  endtask

  initial begin
    m_pc = RESET_VECTOR; m_out = 1'b0; m_stale = 1'b0;
    test_reset();
    test_sequential();
    test_redirect_idle();
    test_branch_busy();
    test_jump_same_cycle();
    test_stall_and_reset_busy();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
